// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage (master)
// and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU ops straight through, stalls EX while a load/store
// waits on the data memory. Optional WAIT timeout enabled by MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_mem2reg,
    input  logic        ex_pcwrite,
    input  logic [15:0] ex_aluout,
    input  logic [15:0] ex_wdata,
    input  logic [3:0]  ex_rd,
    mem_stage_if.master dmem,
    output logic        mem_valid,
    output logic [15:0] mem_memout,
    output logic [15:0] mem_aluout,
    output logic [3:0]  mem_rd,
    output logic        mem2reg_out,
    output logic        pcwrite_out,
    output logic        stall_out,
    output logic        mem_fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must lie in 2..256");
    end

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        access;
    logic        timeout_hit;

    logic [15:0] h_aluout;
    logic [15:0] h_wdata;
    logic [3:0]  h_rd;
    logic        h_mem2reg;
    logic        h_pcwrite;
    logic        h_memread;
    logic        h_memwrite;
    logic [15:0] h_memout;
    logic        fault_now;

    assign access = ex_valid & (ex_memread | ex_memwrite);

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_count;
    logic       h_fault;

    assign timeout_hit = (state == WAIT) && !dmem.dmem_ack && (wait_count == TIMEOUT_LAST);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wait_count <= 8'd0;
            h_fault    <= 1'b0;
        end else if (state == IDLE && access) begin
            wait_count <= 8'd0;
            h_fault    <= 1'b0;
        end else if (state == WAIT && !dmem.dmem_ack) begin
            wait_count <= wait_count + 8'd1;
            h_fault    <= timeout_hit;
        end
    end

    assign fault_now = (state == DONE) && h_fault;
`else
    assign timeout_hit = 1'b0;
    assign fault_now   = 1'b0;
`endif

    assign mem_fault = fault_now;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access) state_next = WAIT;
            WAIT:    if (dmem.dmem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A combined read+write is held as a pure store so no load data is captured.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            h_aluout   <= 16'd0;
            h_wdata    <= 16'd0;
            h_rd       <= 4'd0;
            h_mem2reg  <= 1'b0;
            h_pcwrite  <= 1'b0;
            h_memread  <= 1'b0;
            h_memwrite <= 1'b0;
            h_memout   <= 16'd0;
        end else if (state == IDLE && access) begin
            h_aluout   <= ex_aluout;
            h_wdata    <= ex_wdata;
            h_rd       <= ex_rd;
            h_mem2reg  <= ex_mem2reg;
            h_pcwrite  <= ex_pcwrite;
            h_memread  <= ex_memread & ~ex_memwrite;
            h_memwrite <= ex_memwrite;
            h_memout   <= 16'd0;
        end else if (state == WAIT && dmem.dmem_ack) begin
            h_memout   <= h_memread ? dmem.dmem_rdata : 16'd0;
        end
    end

    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = 16'd0;
        dmem.dmem_wdata = 16'd0;
        mem_valid       = 1'b0;
        mem_memout      = 16'd0;
        mem_aluout      = h_aluout;
        mem_rd          = h_rd;
        mem2reg_out     = h_mem2reg;
        pcwrite_out     = 1'b0;
        stall_out       = 1'b0;
        case (state)
            IDLE: begin
                mem_aluout  = ex_aluout;
                mem_rd      = ex_rd;
                mem2reg_out = ex_mem2reg;
                mem_valid   = ex_valid & ~access;
                pcwrite_out = ex_valid & ~access & ex_pcwrite;
                stall_out   = access;
            end
            WAIT: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = h_memwrite;
                dmem.dmem_addr  = h_aluout;
                dmem.dmem_wdata = h_wdata;
                stall_out       = 1'b1;
            end
            DONE: begin
                mem_valid   = 1'b1;
                mem_memout  = fault_now ? 16'd0 : h_memout;
                mem2reg_out = h_mem2reg & ~fault_now;
                pcwrite_out = h_pcwrite & ~fault_now;
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, bubbles, loads,
// stores, reset during WAIT, and the WAIT timeout when MEM_STAGE_TIMEOUT_EN is set.
module tb_mem_stage;

    logic        clock;
    logic        rst;
    logic        ex_valid;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_mem2reg;
    logic        ex_pcwrite;
    logic [15:0] ex_aluout;
    logic [15:0] ex_wdata;
    logic [3:0]  ex_rd;
    logic        mem_valid;
    logic [15:0] mem_memout;
    logic [15:0] mem_aluout;
    logic [3:0]  mem_rd;
    logic        mem2reg_out;
    logic        pcwrite_out;
    logic        stall_out;
    logic        mem_fault;

    int vectors;
    int miscompares;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .ex_mem2reg  (ex_mem2reg),
        .ex_pcwrite  (ex_pcwrite),
        .ex_aluout   (ex_aluout),
        .ex_wdata    (ex_wdata),
        .ex_rd       (ex_rd),
        .dmem        (dmem_bus),
        .mem_valid   (mem_valid),
        .mem_memout  (mem_memout),
        .mem_aluout  (mem_aluout),
        .mem_rd      (mem_rd),
        .mem2reg_out (mem2reg_out),
        .pcwrite_out (pcwrite_out),
        .stall_out   (stall_out),
        .mem_fault   (mem_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic memread, input logic memwrite,
                                 input logic mem2reg, input logic pcwrite,
                                 input logic [15:0] aluout, input logic [15:0] wdata,
                                 input logic [3:0] rd);
        ex_valid    = valid;
        ex_memread  = memread;
        ex_memwrite = memwrite;
        ex_mem2reg  = mem2reg;
        ex_pcwrite  = pcwrite;
        ex_aluout   = aluout;
        ex_wdata    = wdata;
        ex_rd       = rd;
    endtask

    // Advance one rising edge and step just past it so inputs change away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setAck(input logic ack, input logic [15:0] rdata);
        dmem_bus.dmem_ack   = ack;
        dmem_bus.dmem_rdata = rdata;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
        setAck(0, 16'h0000);
        #2;
        checkOutput("reset_req", {15'd0, dmem_bus.dmem_req}, 16'd0);
        checkOutput("reset_valid", {15'd0, mem_valid}, 16'd0);
        checkOutput("reset_stall", {15'd0, stall_out}, 16'd0);
        checkOutput("reset_fault", {15'd0, mem_fault}, 16'd0);
        tick();
        tick();
        rst = 1'b1;

        // ALU op passes straight through in the same cycle
        tick();
        applyStimulus(1, 0, 0, 0, 1, 16'h1234, 16'h0000, 4'd3);
        #1;
        checkOutput("alu_valid", {15'd0, mem_valid}, 16'd1);
        checkOutput("alu_aluout", mem_aluout, 16'h1234);
        checkOutput("alu_rd", {12'd0, mem_rd}, 16'd3);
        checkOutput("alu_stall", {15'd0, stall_out}, 16'd0);
        checkOutput("alu_req", {15'd0, dmem_bus.dmem_req}, 16'd0);
        checkOutput("alu_pcwrite", {15'd0, pcwrite_out}, 16'd1);
        checkOutput("alu_memout", mem_memout, 16'd0);

        // Bubble: nothing valid, no PC write even if the control bit is set
        tick();
        applyStimulus(0, 0, 0, 1, 1, 16'h5555, 16'h0000, 4'd7);
        #1;
        checkOutput("bubble_valid", {15'd0, mem_valid}, 16'd0);
        checkOutput("bubble_pcwrite", {15'd0, pcwrite_out}, 16'd0);
        checkOutput("bubble_req", {15'd0, dmem_bus.dmem_req}, 16'd0);

        // Load from 0x0040, ack on the second WAIT cycle
        tick();
        applyStimulus(1, 1, 0, 1, 1, 16'h0040, 16'h0000, 4'd5);
        #1;
        checkOutput("ld_idle_stall", {15'd0, stall_out}, 16'd1);
        checkOutput("ld_idle_valid", {15'd0, mem_valid}, 16'd0);
        checkOutput("ld_idle_pcwrite", {15'd0, pcwrite_out}, 16'd0);
        checkOutput("ld_idle_req", {15'd0, dmem_bus.dmem_req}, 16'd0);
        tick();
        #1;
        checkOutput("ld_w1_req", {15'd0, dmem_bus.dmem_req}, 16'd1);
        checkOutput("ld_w1_addr", dmem_bus.dmem_addr, 16'h0040);
        checkOutput("ld_w1_we", {15'd0, dmem_bus.dmem_we}, 16'd0);
        checkOutput("ld_w1_stall", {15'd0, stall_out}, 16'd1);
        checkOutput("ld_w1_valid", {15'd0, mem_valid}, 16'd0);
        tick();
        setAck(1, 16'hBEEF);
        #1;
        checkOutput("ld_w2_req", {15'd0, dmem_bus.dmem_req}, 16'd1);
        checkOutput("ld_w2_stall", {15'd0, stall_out}, 16'd1);
        tick();
        setAck(0, 16'h0000);
        #1;
        checkOutput("ld_done_valid", {15'd0, mem_valid}, 16'd1);
        checkOutput("ld_done_memout", mem_memout, 16'hBEEF);
        checkOutput("ld_done_aluout", mem_aluout, 16'h0040);
        checkOutput("ld_done_rd", {12'd0, mem_rd}, 16'd5);
        checkOutput("ld_done_mem2reg", {15'd0, mem2reg_out}, 16'd1);
        checkOutput("ld_done_pcwrite", {15'd0, pcwrite_out}, 16'd1);
        checkOutput("ld_done_stall", {15'd0, stall_out}, 16'd0);
        checkOutput("ld_done_req", {15'd0, dmem_bus.dmem_req}, 16'd0);
        checkOutput("ld_done_fault", {15'd0, mem_fault}, 16'd0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 16'h7777, 16'h0000, 4'd9);
        #1;
        checkOutput("ld_next_valid", {15'd0, mem_valid}, 16'd1);
        checkOutput("ld_next_aluout", mem_aluout, 16'h7777);
        checkOutput("ld_next_stall", {15'd0, stall_out}, 16'd0);

        // Store to 0x0010, ack in the first WAIT cycle; rdata must be ignored
        tick();
        applyStimulus(1, 0, 1, 0, 1, 16'h0010, 16'hA5A5, 4'd2);
        #1;
        checkOutput("st_idle_stall", {15'd0, stall_out}, 16'd1);
        tick();
        setAck(1, 16'h1111);
        #1;
        checkOutput("st_w1_we", {15'd0, dmem_bus.dmem_we}, 16'd1);
        checkOutput("st_w1_wdata", dmem_bus.dmem_wdata, 16'hA5A5);
        checkOutput("st_w1_addr", dmem_bus.dmem_addr, 16'h0010);
        tick();
        setAck(0, 16'h0000);
        #1;
        checkOutput("st_done_memout", mem_memout, 16'h0000);
        checkOutput("st_done_valid", {15'd0, mem_valid}, 16'd1);
        checkOutput("st_done_we", {15'd0, dmem_bus.dmem_we}, 16'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
        #1;
        checkOutput("st_idle_after", {15'd0, mem_valid}, 16'd0);

        // Read and write together behave as a store
        tick();
        applyStimulus(1, 1, 1, 1, 0, 16'h0020, 16'h5A5A, 4'd4);
        tick();
        setAck(1, 16'h2222);
        #1;
        checkOutput("rw_we", {15'd0, dmem_bus.dmem_we}, 16'd1);
        checkOutput("rw_wdata", dmem_bus.dmem_wdata, 16'h5A5A);
        tick();
        setAck(0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
        #1;
        checkOutput("rw_done_memout", mem_memout, 16'h0000);
        checkOutput("rw_done_valid", {15'd0, mem_valid}, 16'd1);

        // Reset asserted mid-WAIT drops the request at once; later ack is ignored
        tick();
        applyStimulus(1, 1, 0, 1, 1, 16'h0080, 16'h0000, 4'd6);
        tick();
        #1;
        checkOutput("rstw_req_before", {15'd0, dmem_bus.dmem_req}, 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
        rst = 1'b0;
        #1;
        checkOutput("rstw_req_dropped", {15'd0, dmem_bus.dmem_req}, 16'd0);
        checkOutput("rstw_valid", {15'd0, mem_valid}, 16'd0);
        tick();
        rst = 1'b1;
        setAck(1, 16'h3333);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checkOutput("rstw_no_valid", {15'd0, mem_valid}, 16'd0);
            checkOutput("rstw_no_req", {15'd0, dmem_bus.dmem_req}, 16'd0);
        end
        setAck(0, 16'h0000);

`ifdef MEM_STAGE_TIMEOUT_EN
        // No ack: four WAIT cycles, then a faulted DONE
        tick();
        applyStimulus(1, 1, 0, 1, 1, 16'h00F0, 16'h0000, 4'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
            #1;
            checkOutput("to_wait_req", {15'd0, dmem_bus.dmem_req}, 16'd1);
        end
        tick();
        #1;
        checkOutput("to_done_valid", {15'd0, mem_valid}, 16'd1);
        checkOutput("to_done_fault", {15'd0, mem_fault}, 16'd1);
        checkOutput("to_done_pcwrite", {15'd0, pcwrite_out}, 16'd0);
        checkOutput("to_done_mem2reg", {15'd0, mem2reg_out}, 16'd0);
        checkOutput("to_done_memout", mem_memout, 16'd0);
        tick();
        #1;
        checkOutput("to_idle_fault", {15'd0, mem_fault}, 16'd0);

        // Ack arrives in the fourth WAIT cycle: ack wins over the timeout
        tick();
        applyStimulus(1, 1, 0, 1, 1, 16'h00F2, 16'h0000, 4'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
            if (i == 4) setAck(1, 16'h0001);
            #1;
            checkOutput("tie_wait_req", {15'd0, dmem_bus.dmem_req}, 16'd1);
        end
        tick();
        setAck(0, 16'h0000);
        #1;
        checkOutput("tie_done_memout", mem_memout, 16'h0001);
        checkOutput("tie_done_fault", {15'd0, mem_fault}, 16'd0);
        checkOutput("tie_done_pcwrite", {15'd0, pcwrite_out}, 16'd1);
`else
        // Without the timeout a WAIT holds for as long as the memory takes
        tick();
        applyStimulus(1, 1, 0, 0, 0, 16'h00F0, 16'h0000, 4'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'd0);
        for (int i = 0; i < 70; i++) tick();
        #1;
        checkOutput("long_wait_req", {15'd0, dmem_bus.dmem_req}, 16'd1);
        checkOutput("long_wait_fault", {15'd0, mem_fault}, 16'd0);
        checkOutput("long_wait_valid", {15'd0, mem_valid}, 16'd0);
        setAck(1, 16'h4321);
        tick();
        setAck(0, 16'h0000);
        #1;
        checkOutput("long_done_memout", mem_memout, 16'h4321);
        checkOutput("long_done_fault", {15'd0, mem_fault}, 16'd0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
